// File: rtl/ram8_access_arbiter.sv
// ram8_access_arbiter: round-robin sharing of one single-port RAM8 among NREQ requesters
module ram8_access_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      rdata,
    output logic [WIDTH-1:0]      ram_in,
    output logic                  ram_load,
    output logic [AW-1:0]         ram_address,
    input  logic [WIDTH-1:0]      ram_out,
    output logic                  busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    nxt_ptr;
    logic             found;
    logic             gnt;
    logic [NREQ-1:0]  elig;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] din_q;
    logic [AW-1:0]    a_arr [NREQ];
    logic [WIDTH-1:0] d_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_arr[i] = addr[i*AW +: AW];
        assign d_arr[i] = wdata[i*WIDTH +: WIDTH];
    end
    // a requester being acked this cycle is masked so a held request is served once
    assign elig = req & ~ack;
    // scan from rr_ptr downward in priority order; the last hit (closest to rr_ptr) wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    assign gnt         = found & rst_n;
    assign busy        = gnt;
    assign ram_load    = gnt & we[win];
    assign ram_address = gnt ? a_arr[win] : addr_q;
    assign ram_in      = gnt ? d_arr[win] : din_q;
    assign nxt_ptr     = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    // complete the granted access: one-hot ack, captured data, advance the rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack    <= '0;
            rdata  <= '0;
            rr_ptr <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (gnt) begin
            ack    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            rdata  <= we[win] ? d_arr[win] : ram_out;
            rr_ptr <= nxt_ptr;
            addr_q <= a_arr[win];
            din_q  <= d_arr[win];
        end else begin
            ack <= '0;
        end
    end
endmodule

// File: tb/tb_ram8_access_arbiter.sv
// tb_ram8_access_arbiter: directed vectors plus a cycle-level reference model
module tb_ram8_access_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we, ack;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [15:0] rdata, ram_in, ram_out;
    logic        ram_load, busy;
    logic [2:0]  ram_address;
    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    logic [15:0] bram  [8] = '{default: '0};
    logic [15:0] m_mem [8] = '{default: '0};
    logic [3:0]  m_ack;
    logic [15:0] m_rdata, m_din;
    logic [2:0]  m_addr;
    int          m_ptr;
    int          mw;

    ram8_access_arbiter #(.NREQ(4), .WIDTH(16), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .ram_in(ram_in), .ram_load(ram_load),
        .ram_address(ram_address), .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ram_out = bram[ram_address];
    always @(posedge clk) if (ram_load) bram[ram_address] <= ram_in;

    function automatic int pick(input logic [3:0] r, input logic [3:0] a, input int p);
        for (int k = 0; k < 4; k++) begin
            int i = (p + k) % 4;
            if (r[i] && !a[i]) return i;
        end
        return -1;
    endfunction

    always_comb mw = rst_n ? pick(req, m_ack, m_ptr) : -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack   <= '0;
            m_rdata <= '0;
            m_ptr   <= 0;
            m_addr  <= '0;
            m_din   <= '0;
        end else if (mw < 0) begin
            m_ack <= '0;
        end else begin
            m_ack   <= 4'(1 << mw);
            m_rdata <= we[mw] ? wdata[mw*16 +: 16] : m_mem[addr[mw*3 +: 3]];
            if (we[mw]) m_mem[addr[mw*3 +: 3]] <= wdata[mw*16 +: 16];
            m_ptr   <= (mw + 1) % 4;
            m_addr  <= addr[mw*3 +: 3];
            m_din   <= wdata[mw*16 +: 16];
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_ack", 16'(ack), 16'(m_ack));
            chk("m_rdata", rdata, m_rdata);
            chk("m_busy", 16'(busy), 16'(mw >= 0));
            chk("m_load", 16'(ram_load), (mw >= 0) ? 16'(we[mw]) : 16'd0);
            chk("m_addr", 16'(ram_address), (mw >= 0) ? 16'(addr[mw*3 +: 3]) : 16'(m_addr));
            chk("m_din", ram_in, (mw >= 0) ? wdata[mw*16 +: 16] : m_din);
            chk("onehot", 16'($countones(ack) <= 1), 16'd1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic w, input logic [2:0] a, input logic [15:0] d);
        we[i]          = w;
        addr[i*3 +: 3] = a;
        wdata[i*16 +: 16] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        we    = 4'b1111;
        addr  = {4{3'd3}};
        wdata = {4{16'hFFFF}};
        #1 chk_on = 1'b1;
        repeat (3) begin
            tick;
            chk("rst_ack", 16'(ack), 16'd0);
            chk("rst_load", 16'(ram_load), 16'd0);
            chk("rst_rdata", rdata, 16'd0);
        end
        chk("rst_mem", bram[3], 16'd0);
        req   = '0;
        we    = '0;
        rst_n = 1'b1;
        tick;
        drive(0, 1'b1, 3'd3, 16'hBEEF);
        req = 4'b0001;
        tick;
        chk("wr_ack", 16'(ack), 16'h0001);
        chk("wr_rdata", rdata, 16'hBEEF);
        chk("wr_model", m_rdata, 16'hBEEF);
        we[0] = 1'b0;
        tick;
        chk("masked_ack", 16'(ack), 16'h0000);
        tick;
        chk("rd_ack", 16'(ack), 16'h0001);
        chk("rd_rdata", rdata, 16'hBEEF);
        req = '0;
        tick;
        for (int i = 0; i < 4; i++) begin
            drive(3, 1'b1, 3'(i), 16'(16'h0011 * (i + 1)));
            req = 4'b1000;
            tick;
            chk("pre_ack", 16'(ack), 16'h0008);
            req = '0;
            tick;
        end
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 3'(i), 16'h0);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("cont_ack", 16'(ack), 16'(1 << i));
            chk("cont_rdata", rdata, 16'(16'h0011 * (i + 1)));
        end
        req = '0;
        tick;
        req = 4'b1001;
        tick;
        chk("wrap_ack0", 16'(ack), 16'h0001);
        chk("wrap_rd0", rdata, 16'h0011);
        tick;
        chk("wrap_ack3", 16'(ack), 16'h0008);
        chk("wrap_rd3", rdata, 16'h0044);
        tick;
        chk("wrap_ack0b", 16'(ack), 16'h0001);
        req = '0;
        tick;
        drive(1, 1'b1, 3'd5, 16'h1234);
        req = 4'b0010;
        tick;
        chk("raw_wack", 16'(ack), 16'h0002);
        drive(2, 1'b0, 3'd5, 16'h0);
        req = 4'b0100;
        tick;
        chk("raw_ack", 16'(ack), 16'h0004);
        chk("raw_rdata", rdata, 16'h1234);
        chk("raw_model", m_rdata, 16'h1234);
        req = '0;
        tick;
        drive(3, 1'b0, 3'd0, 16'h0);
        drive(2, 1'b1, 3'd6, 16'hDEAD);
        req = 4'b1100;
        tick;
        chk("wd_ack3", 16'(ack), 16'h0008);
        req = '0;
        tick;
        chk("wd_noack", 16'(ack), 16'h0000);
        chk("wd_mem", bram[6], 16'h0000);
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 3'(i), 16'h0);
        req = 4'b1111;
        tick;
        chk("mr_ack0", 16'(ack), 16'h0001);
        tick;
        chk("mr_ack1", 16'(ack), 16'h0002);
        rst_n = 1'b0;
        #1;
        chk("mr_ack_clr", 16'(ack), 16'h0000);
        chk("mr_rd_clr", rdata, 16'h0000);
        chk("mr_load", 16'(ram_load), 16'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("mr_first", 16'(ack), 16'h0001);
        chk("mr_first_rd", rdata, 16'h0011);
        req = '0;
        tick;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
